// File: rtl/vrf_writeback_if.sv
// Bus bundle between the ALU stage, decode read ports and the writeback/register-file block.
// ALU_WB_en is a valid with no ready: the writeback stage always accepts, so a commit completes on the edge it is presented.
interface vrf_writeback_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [0:DATA_W-1] ALU_output_up;
    logic [0:4]        ALU_PPPWW;
    logic [0:ADDR_W-1] ALU_rD;
    logic              ALU_WB_en;
    logic [0:ADDR_W-1] ID_rA_addr;
    logic [0:ADDR_W-1] ID_rB_addr;
    logic [0:DATA_W-1] ID_rA_data;
    logic [0:DATA_W-1] ID_rB_data;
    logic              WB_wr_en;
    logic [0:ADDR_W-1] WB_rD;
    logic [0:DATA_W-1] WB_wr_mask;

    modport master (
        output ALU_output_up, ALU_PPPWW, ALU_rD, ALU_WB_en, ID_rA_addr, ID_rB_addr,
        input  ID_rA_data, ID_rB_data, WB_wr_en, WB_rD, WB_wr_mask
    );

    modport slave (
        input  ALU_output_up, ALU_PPPWW, ALU_rD, ALU_WB_en, ID_rA_addr, ID_rB_addr,
        output ID_rA_data, ID_rB_data, WB_wr_en, WB_rD, WB_wr_mask
    );
endinterface

// File: rtl/vrf_writeback.sv
// Writeback stage and 32 x 64-bit vector register file with per-element write masking
// and write-through bypass on both decode read ports. Bit 0 is the MSB throughout.
module vrf_writeback #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input logic             clk,
    input logic             reset,
    vrf_writeback_if.slave  bus
);

    logic [0:DATA_W-1] rf [NREGS];
    logic [2:0]        ppp;
    logic [1:0]        ww;
    logic [0:DATA_W-1] wr_mask;
    logic [0:DATA_W-1] merged;
    logic              commit;

    assign ppp = bus.ALU_PPPWW[0:2];
    assign ww  = bus.ALU_PPPWW[3:4];

    // Element index of bit i is i / (8 << ww); element 0 holds the most significant bits.
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            case (ppp)
                3'b000:  wr_mask[i] = 1'b1;
                3'b001:  wr_mask[i] = (i < DATA_W / 2);
                3'b010:  wr_mask[i] = (i >= DATA_W / 2);
                3'b011:  wr_mask[i] = (((i >> (3 + int'(ww))) % 2) == 0);
                3'b100:  wr_mask[i] = (((i >> (3 + int'(ww))) % 2) == 1);
                default: wr_mask[i] = 1'b0;
            endcase
        end
    end

    assign commit = bus.ALU_WB_en && (wr_mask != '0);
    assign merged = (rf[bus.ALU_rD] & ~wr_mask) | (bus.ALU_output_up & wr_mask);

    // With a zero mask the merged value equals the stored value, so bypass can key on enable alone.
    assign bus.ID_rA_data = (bus.ALU_WB_en && (bus.ALU_rD == bus.ID_rA_addr)) ? merged
                                                                            : rf[bus.ID_rA_addr];
    assign bus.ID_rB_data = (bus.ALU_WB_en && (bus.ALU_rD == bus.ID_rB_addr)) ? merged
                                                                            : rf[bus.ID_rB_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                rf[r] <= '0;
            end
            bus.WB_wr_en   <= 1'b0;
            bus.WB_rD      <= '0;
            bus.WB_wr_mask <= '0;
        end else begin
            if (commit) begin
                rf[bus.ALU_rD] <= merged;
            end
            bus.WB_wr_en   <= commit;
            bus.WB_rD      <= bus.ALU_rD;
            bus.WB_wr_mask <= commit ? wr_mask : '0;
        end
    end

endmodule
